cacheline_adapter: RTL

//  Memory-side responder for the cache's dfp line interface (dfp_addr/read/write/rdata/wdata/resp).

---
 rtl/cacheline_adapter_pkg.sv | 28 ++
 rtl/cacheline_adapter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared constants and state type for the cache line adapter, so the cache,
// the adapter and the burst memory model all agree on line/beat geometry.
package cacheline_adapter_pkg;

    localparam int unsigned LINE_W     = 256;
    localparam int unsigned BEAT_W     = 64;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BURST_LEN  = LINE_W / BEAT_W;
    localparam int unsigned CNT_W      = $clog2(BURST_LEN);
    localparam int unsigned LINE_BYTES = LINE_W / 8;

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdData,
        StWrData,
        StResp
    } adapter_state_t;

    // Clears the byte-within-line bits of an address.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Memory-side responder for the cache's line interface. Each 256-bit line
// read or write-back becomes a 4-beat x 64-bit burst on the bmem port; the
// cache is answered with a one-cycle dfp_resp_o pulse. One request at a time.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   dfp_addr_i            line address from the cache (held with the request)
//   dfp_read_i/write_i    level requests, held until dfp_resp_o
//   dfp_wdata_i           write-back line
//   dfp_rdata_o           assembled read line, valid with dfp_resp_o
//   dfp_resp_o            one-cycle completion pulse
//   bmem_addr_o           line-aligned burst address
//   bmem_read_o           burst read command, held until bmem_ready_i
//   bmem_write_o          write beat valid, high for every beat of a write burst
//   bmem_wdata_o          current write beat (beat 0 = line bits [63:0])
//   bmem_ready_i          memory accepts command/beat this cycle
//   bmem_raddr_i          tag of returning read data
//   bmem_rdata_i          read beat
//   bmem_rvalid_i         read beat valid
//   proto_err_o           high in any cycle with an illegal interface condition:
//                         read and write together in idle, rvalid outside a
//                         read burst, or a read beat tagged with the wrong line
module cacheline_adapter
    import cacheline_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dfp_addr_i,
    input  logic              dfp_read_i,
    input  logic              dfp_write_i,
    input  logic [LINE_W-1:0] dfp_wdata_i,
    output logic [LINE_W-1:0] dfp_rdata_o,
    output logic              dfp_resp_o,
    output logic [ADDR_W-1:0] bmem_addr_o,
    output logic              bmem_read_o,
    output logic              bmem_write_o,
    output logic [BEAT_W-1:0] bmem_wdata_o,
    input  logic              bmem_ready_i,
    input  logic [ADDR_W-1:0] bmem_raddr_i,
    input  logic [BEAT_W-1:0] bmem_rdata_i,
    input  logic              bmem_rvalid_i,
    output logic              proto_err_o
);

    adapter_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BURST_LEN-1:0][BEAT_W-1:0] wbuf_q, wbuf_d;
    logic [BURST_LEN-1:0][BEAT_W-1:0] line_q, line_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wbuf_d       = wbuf_q;
        line_d       = line_q;
        bmem_read_o  = 1'b0;
        bmem_write_o = 1'b0;
        bmem_wdata_o = '0;
        dfp_resp_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Read wins when both requests are (illegally) raised together.
                if (dfp_read_i) begin
                    addr_d  = line_align(dfp_addr_i);
                    state_d = StRdReq;
                end else if (dfp_write_i) begin
                    addr_d  = line_align(dfp_addr_i);
                    wbuf_d  = dfp_wdata_i;
                    cnt_d   = '0;
                    state_d = StWrData;
                end
            end
            StRdReq: begin
                bmem_read_o = 1'b1;
                if (bmem_ready_i) begin
                    cnt_d   = '0;
                    state_d = StRdData;
                end
            end
            StRdData: begin
                if (bmem_rvalid_i) begin
                    line_d[cnt_q] = bmem_rdata_i;
                    cnt_d         = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = StResp;
                    end
                end
            end
            StWrData: begin
                bmem_write_o = 1'b1;
                bmem_wdata_o = wbuf_q[cnt_q];
                if (bmem_ready_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                dfp_resp_o = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line buffer only changes on read beats, so it still holds the last read
    // line while a write-back is in flight.
    assign dfp_rdata_o = line_q;
    assign bmem_addr_o = addr_q;

    assign proto_err_o = (state_q == StIdle && dfp_read_i && dfp_write_i)
                       || (bmem_rvalid_i && state_q != StRdData)
                       || (bmem_rvalid_i && state_q == StRdData && bmem_raddr_i != addr_q);

endmodule
